iob_cache_write_buffer: RTL and testbench
=========================================

Name: iob_cache_write_buffer

Overview:
- Write-through staging FIFO between the cache front-end/controller and the back-end write channel.
- Accepts word writes `{addr, wdata, wstrb}` and drains them in order through a valid/ready handshake.
- Optionally coalesces a write into the most recent pending entry when the address matches.
- Provides empty, full and level status plus an address-hit lookup, so the controller stalls only reads that would otherwise return stale data.

Parameters:
- ADDR_W, 24, byte address width.
- DATA_W, 32, front-end word width; a multiple of 8.
- DEPTH_W, 2, log2 of entry count (DEPTH = 2**DEPTH_W); must be ≥ 1.
- MERGE_EN, 1, enables write coalescing into the tail entry.
- NBYTES, DATA_W/8, derived.
- NBYTES_W, $clog2(NBYTES), derived.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- push_i  in  1  write request from the controller.
- push_addr_i  in  ADDR_W-NBYTES_W  word address.
- push_wdata_i  in  DATA_W  write data.
- push_wstrb_i  in  NBYTES  byte enables.
- push_ready_o  out  1  write accepted this cycle.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  write channel accepts the head entry.
- out_addr_o  out  ADDR_W-NBYTES_W  head address.
- out_wdata_o  out  DATA_W  head data.
- out_wstrb_o  out  NBYTES  head byte enables.
- lookup_addr_i  in  ADDR_W-NBYTES_W  read address to check.
- lookup_hit_o  out  1  some pending entry matches lookup_addr_i.
- empty_o  out  1  no pending entries.
- full_o  out  1  DEPTH pending entries.
- level_o  out  DEPTH_W+1  pending entry count.

Behaviour:
- Storage: DEPTH entries in a register array; read pointer rd_ptr and write pointer wr_ptr, each DEPTH_W bits, wrapping modulo DEPTH; level counter level_o.
- Reset (synchronous): rd_ptr = wr_ptr = 0 and level = 0.
  - Resulting outputs: empty_o = 1, full_o = 0, out_valid_o = 0, lookup_hit_o = 0, push_ready_o = 1.
  - Entry contents are don't-care.
  - Reset mid-drain discards every pending entry; the downstream stage is reset by the same reset.
- Flags: empty_o = (level == 0), full_o = (level == DEPTH), out_valid_o = ~empty_o. All are decoded from registers; there are no combinational paths from out_ready_i or push_i.
- Output data: out_addr_o, out_wdata_o and out_wstrb_o show entry[rd_ptr] combinationally and are stable while out_valid_o is high and out_ready_i is low.
- Pop: occurs when out_valid_o & out_ready_i. rd_ptr increments; out_ready_i is ignored while empty.
- Merge condition (MERGE_EN = 1): push_i & ~empty_o & (push_addr_i == tail addr), where tail = wr_ptr-1, AND NOT (level == 1 & pop this cycle).
  - In the excluded case the tail is the head leaving this cycle, so the write becomes a normal push.
- Merge action:
  - For each byte b with push_wstrb_i[b] set, tail wdata byte b is overwritten.
  - Tail wstrb becomes tail wstrb OR push_wstrb_i.
  - level and pointers are unchanged.
  - Merge is allowed when full.
- push_ready_o = ~full_o | merge_condition.
- Push: occurs when push_i & push_ready_o & ~merge. The entry is written at wr_ptr and wr_ptr increments.
- A push while full that cannot merge is not accepted (push_ready_o = 0); the controller holds the request.
- Latency: a push into an empty buffer gives out_valid_o = 1 on the next cycle. Throughput is 1 push and 1 pop per cycle.
- Simultaneous push and pop: level is unchanged. When full, a push is not accepted even if a pop occurs the same cycle; it is accepted one cycle later.
- Level update: level += push_accepted_nonmerge - pop.
- Wrap-around: pointers wrap silently; correctness relies on the level counter, not on pointer comparison.
- lookup_hit_o: OR over i < level of (entry[(rd_ptr+i) mod DEPTH].addr == lookup_addr_i). It is combinational, does not include the entry being pushed this cycle, and is 0 when empty.
- A zero push_wstrb_i is still stored or merged; no special case.

Test Plan:
- Reset, push addr 0x10 data 0xAABBCCDD wstrb 0xF, out_ready_i = 0 → next cycle out_valid_o = 1, out_addr_o = 0x10, out_wdata_o = 0xAABBCCDD, level_o = 1. Then out_ready_i = 1 for one cycle → empty_o = 1.
- DEPTH = 4, out_ready_i = 0, push addrs 1, 2, 3, 4 → full_o = 1, level_o = 4. A push to addr 5 gives push_ready_o = 0 and is dropped. Drain yields 1, 2, 3, 4 in order.
- Merge: push addr 7 data 0x11111111 wstrb 0x3, then addr 7 data 0x22222222 wstrb 0xC → level_o = 1, out_wdata_o = 0x22221111, out_wstrb_o = 0xF.
- Merge-vs-pop hazard: level = 1 with head addr 7, pop and push addr 7 in the same cycle → push stored as a new entry, level_o stays 1, next head wstrb equals only the new wstrb.
- Wrap and lookup: run 10 push/pop cycles so the pointers wrap. With pending addrs {0x20, 0x21}, lookup 0x21 → lookup_hit_o = 1; lookup 0x22 → 0. After drain, lookup 0x21 → 0.
- Reset asserted with level = 3 → next cycle empty_o = 1, out_valid_o = 0, level_o = 0, lookup_hit_o = 0.

Source files
------------

// File: rtl/iob_cache_write_buffer.sv
// iob_cache_write_buffer
//
// Write-through staging FIFO between the cache controller and the back-end
// write channel. Word writes {addr, wdata, wstrb} are queued and drained in
// order through a valid/ready handshake. When MERGE_EN is set, a write whose
// address matches the most recent pending entry (the tail) is coalesced into
// it instead of taking a new slot. An address lookup reports whether a read
// address is still pending, so only reads that would see stale data stall.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   push_i                  write request from the controller
//   push_addr_i/_wdata_i/_wstrb_i  word address, data, byte enables
//   push_ready_o            write accepted this cycle (stored or merged)
//   out_valid_o/out_ready_i head handshake toward the write channel
//   out_addr_o/_wdata_o/_wstrb_o   head entry contents
//   lookup_addr_i           read address to check
//   lookup_hit_o            some pending entry matches lookup_addr_i
//   empty_o, full_o, level_o  occupancy status

module iob_cache_write_buffer #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int DEPTH_W  = 2,
    parameter int MERGE_EN = 1,
    parameter int NBYTES   = DATA_W / 8,
    parameter int NBYTES_W = $clog2(NBYTES)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       push_i,
    input  logic [ADDR_W-NBYTES_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0]          push_wdata_i,
    input  logic [NBYTES-1:0]          push_wstrb_i,
    output logic                       push_ready_o,

    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ADDR_W-NBYTES_W-1:0] out_addr_o,
    output logic [DATA_W-1:0]          out_wdata_o,
    output logic [NBYTES-1:0]          out_wstrb_o,

    input  logic [ADDR_W-NBYTES_W-1:0] lookup_addr_i,
    output logic                       lookup_hit_o,

    output logic                       empty_o,
    output logic                       full_o,
    output logic [DEPTH_W:0]           level_o
);

    localparam int AW    = ADDR_W - NBYTES_W;
    localparam int DEPTH = 2 ** DEPTH_W;

    localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W + 1)'(DEPTH);
    localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

    // Entry storage; contents are not reset, occupancy is tracked by level_q.
    logic [AW-1:0]     addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NBYTES-1:0] strb_mem [DEPTH];

    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W:0]   level_q;

    logic [DEPTH_W-1:0] tail_ptr;
    logic               empty;
    logic               full;
    logic               pop;
    logic               merge;
    logic               push_acc;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_FULL);
    assign tail_ptr = wr_ptr - PTR_ONE;
    assign pop      = ~empty & out_ready_i;

    // A single pending entry that is popping this cycle is no longer a safe
    // merge target: the write is queued as a fresh entry instead.
    assign merge = (MERGE_EN != 0) & push_i & ~empty
                 & (push_addr_i == addr_mem[tail_ptr])
                 & ~((level_q == LVL_ONE) & pop);

    // Full blocks a new slot even when a pop happens in the same cycle; this
    // keeps push_ready_o free of any path from out_ready_i except via merge.
    assign push_ready_o = ~full | merge;
    assign push_acc     = push_i & push_ready_o & ~merge;

    assign out_valid_o = ~empty;
    assign empty_o     = empty;
    assign full_o      = full;
    assign level_o     = level_q;
    assign out_addr_o  = addr_mem[rd_ptr];
    assign out_wdata_o = data_mem[rd_ptr];
    assign out_wstrb_o = strb_mem[rd_ptr];

    // Control state: pointers wrap freely, level_q is the source of truth.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
            case ({push_acc, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Entry data: new slot on push, byte-wise overlay into the tail on merge.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            addr_mem[wr_ptr] <= push_addr_i;
            data_mem[wr_ptr] <= push_wdata_i;
            strb_mem[wr_ptr] <= push_wstrb_i;
        end else if (merge) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (push_wstrb_i[b]) begin
                    data_mem[tail_ptr][8*b +: 8] <= push_wdata_i[8*b +: 8];
                end
            end
            strb_mem[tail_ptr] <= strb_mem[tail_ptr] | push_wstrb_i;
        end
    end

    // Only slots within the pending window (rd_ptr .. rd_ptr+level-1) count.
    always_comb begin
        lookup_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((DEPTH_W + 1)'(i) < level_q) &&
                (addr_mem[rd_ptr + DEPTH_W'(i)] == lookup_addr_i)) begin
                lookup_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
module tb_iob_cache_write_buffer;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int DEPTH_W  = 2;
    localparam int MERGE_EN = 1;
    localparam int NB       = DATA_W / 8;
    localparam int NBW      = $clog2(NB);
    localparam int AW       = ADDR_W - NBW;
    localparam int DEPTH    = 2 ** DEPTH_W;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              push_i = 1'b0;
    logic [AW-1:0]     push_addr_i = '0;
    logic [DATA_W-1:0] push_wdata_i = '0;
    logic [NB-1:0]     push_wstrb_i = '0;
    logic              push_ready_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [AW-1:0]     out_addr_o;
    logic [DATA_W-1:0] out_wdata_o;
    logic [NB-1:0]     out_wstrb_o;
    logic [AW-1:0]     lookup_addr_i = '0;
    logic              lookup_hit_o;
    logic              empty_o;
    logic              full_o;
    logic [DEPTH_W:0]  level_o;

    iob_cache_write_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .MERGE_EN(MERGE_EN)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .push_i(push_i), .push_addr_i(push_addr_i), .push_wdata_i(push_wdata_i),
        .push_wstrb_i(push_wstrb_i), .push_ready_o(push_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_wdata_o(out_wdata_o), .out_wstrb_o(out_wstrb_o),
        .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     strb;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a plain queue of pending writes, oldest first.
    function automatic bit model_merge();
        bit pop;
        pop = (q.size() > 0) && out_ready_i;
        return (MERGE_EN != 0) && push_i && (q.size() > 0) &&
               (q[q.size()-1].addr == push_addr_i) && !((q.size() == 1) && pop);
    endfunction

    function automatic bit model_hit();
        foreach (q[i]) if (q[i].addr == lookup_addr_i) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit mrg;
        mrg = model_merge();
        check("empty", empty_o, q.size() == 0);
        check("full", full_o, q.size() == DEPTH);
        check("level", level_o, q.size());
        check("out_valid", out_valid_o, q.size() != 0);
        check("push_ready", push_ready_o, (q.size() < DEPTH) || mrg);
        check("lookup_hit", lookup_hit_o, model_hit());
        if (q.size() > 0) begin
            check("out_addr", out_addr_o, q[0].addr);
            check("out_wdata", out_wdata_o, q[0].data);
            check("out_wstrb", out_wstrb_o, q[0].strb);
        end
    endtask

    task automatic model_update();
        bit   mrg, pop, acc;
        ent_t t;
        if (reset_i) begin
            q.delete();
            return;
        end
        mrg = model_merge();
        pop = (q.size() > 0) && out_ready_i;
        acc = push_i && !mrg && (q.size() < DEPTH);
        if (mrg) begin
            t = q[q.size()-1];
            for (int b = 0; b < NB; b++)
                if (push_wstrb_i[b]) t.data[8*b +: 8] = push_wdata_i[8*b +: 8];
            t.strb = t.strb | push_wstrb_i;
            q[q.size()-1] = t;
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            t.addr = push_addr_i;
            t.data = push_wdata_i;
            t.strb = push_wstrb_i;
            q.push_back(t);
        end
    endtask

    // One clock cycle: drive, check before the edge, advance the model.
    task automatic step(input logic rst, input logic psh, input logic [AW-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [NB-1:0] s,
                        input logic rdy, input logic [AW-1:0] la);
        reset_i = rst; push_i = psh; push_addr_i = a; push_wdata_i = d;
        push_wstrb_i = s; out_ready_i = rdy; lookup_addr_i = la;
        @(negedge clk_i);
        check_outputs();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, '0, rdy, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        check("rst_empty", empty_o, 1);
        check("rst_ready", push_ready_o, 1);

        // Single write, latency and single pop.
        step(1'b0, 1'b1, 'h10, 32'hAABBCCDD, 4'hF, 1'b0, '0);
        check("t1_valid", out_valid_o, 1);
        check("t1_addr", out_addr_o, 'h10);
        check("t1_data", out_wdata_o, 32'hAABBCCDD);
        check("t1_level", level_o, 1);
        idle(1'b1);
        check("t1_empty", empty_o, 1);

        // Fill, blocked push, in-order drain.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, AW'(i), 32'h100 + i, 4'hF, 1'b0, '0);
        check("fill_full", full_o, 1);
        check("fill_level", level_o, 4);
        step(1'b0, 1'b1, 'h5, 32'h105, 4'hF, 1'b0, '0);
        check("fill_level_hold", level_o, 4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_addr", out_addr_o, i);
            idle(1'b1);
        end
        check("drain_empty", empty_o, 1);

        // Merge into tail.
        step(1'b0, 1'b1, 'h7, 32'h11111111, 4'h3, 1'b0, '0);
        step(1'b0, 1'b1, 'h7, 32'h22222222, 4'hC, 1'b0, '0);
        check("merge_level", level_o, 1);
        check("merge_data", out_wdata_o, 32'h22221111);
        check("merge_strb", out_wstrb_o, 4'hF);

        // Merge-vs-pop hazard: single entry leaving, same address arrives.
        step(1'b0, 1'b1, 'h7, 32'h33333333, 4'h1, 1'b1, '0);
        check("hazard_level", level_o, 1);
        check("hazard_strb", out_wstrb_o, 4'h1);
        check("hazard_byte0", out_wdata_o[7:0], 8'h33);
        idle(1'b1);

        // Wrap pointers, then lookup.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, AW'('h30 + i), $urandom, 4'hF, 1'b1, '0);
        idle(1'b1);
        step(1'b0, 1'b1, 'h20, 32'h20, 4'hF, 1'b0, '0);
        step(1'b0, 1'b1, 'h21, 32'h21, 4'hF, 1'b0, '0);
        lookup_addr_i = 'h21; #1;
        check("lookup_hit21", lookup_hit_o, 1);
        lookup_addr_i = 'h22; #1;
        check("lookup_miss22", lookup_hit_o, 0);
        idle(1'b1);
        idle(1'b1);
        lookup_addr_i = 'h21; #1;
        check("lookup_drained", lookup_hit_o, 0);

        // Reset with pending entries.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'('h40 + i), 32'h0, 4'hF, 1'b0, '0);
        check("pre_rst_level", level_o, 3);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 'h41);
        lookup_addr_i = 'h41; #1;
        check("mid_rst_empty", empty_o, 1);
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_level", level_o, 0);
        check("mid_rst_hit", lookup_hit_o, 0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 AW'($urandom_range(0, 5)), $urandom, NB'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0 ? 1'b0 : 1'b1, AW'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
